boreal_gate_engine: RTL and testbench

- Parametrised policy engine for the Boreal Gate at base 0x1004_0000.
- Holds an N-target allowlist and a rate limiter configured over MMIO.
- Adds what the previous policy block lacked: a commit request/decision handshake, an enforced windowed rate limiter, a sticky configuration lock, fuse gating of the debug override, an internal grant nonce and a deny counter.
- Sits between the commit path (requester) and the MMIO fabric.

---
 rtl/boreal_gate_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_boreal_gate_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_gate_engine.sv
// Boreal Gate policy engine: MMIO-configured allowlist, windowed rate limiter and
// config lock, deciding commit requests with a one-cycle registered response pulse.
module boreal_gate_engine #(
    parameter int unsigned NUM_TARGETS = 64,
    parameter int unsigned TGT_W       = 6,
    parameter int unsigned ALLOW_WORDS = NUM_TARGETS / 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ack,
    input  logic             lock_fuse,
    input  logic             req_valid,
    input  logic [TGT_W-1:0] req_target,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_grant,
    output logic [1:0]       resp_reason,
    output logic [31:0]      nonce
);

    localparam int unsigned IDX_W = $clog2(NUM_TARGETS);

    localparam logic [1:0] ReasonOk         = 2'd0;
    localparam logic [1:0] ReasonDisabled   = 2'd1;
    localparam logic [1:0] ReasonNotAllowed = 2'd2;
    localparam logic [1:0] ReasonRate       = 2'd3;

    localparam logic [5:0] WordCtrl     = 6'h00;
    localparam logic [5:0] WordRateLim  = 6'h02;
    localparam logic [5:0] WordRateWin  = 6'h03;
    localparam logic [5:0] WordPolicy   = 6'h04;
    localparam logic [5:0] WordOverride = 6'h05;
    localparam logic [5:0] WordNonce    = 6'h06;
    localparam logic [5:0] WordDenyCnt  = 6'h07;
    localparam logic [5:0] WordStatus   = 6'h08;

    typedef enum logic {StIdle, StResp} state_e;

    state_e      state_q;
    logic        ctrl_en_q, ctrl_lock_q;
    logic [31:0] allow_q [ALLOW_WORDS];
    logic [31:0] rate_lim_q, rate_win_q, policy_q, override_q;
    logic [31:0] nonce_q, deny_cnt_q, win_cnt_q, commit_cnt_q;
    logic [31:0] rdata_q;
    logic        ack_q, req_ready_q, resp_valid_q, resp_grant_q;
    logic [1:0]  resp_reason_q;

    logic [5:0]             word;
    logic                   mmio_go, cfg_wr, rate_win_wr;
    logic [31:0]            rd_allow, rd_mux;
    logic [NUM_TARGETS-1:0] allow_flat;
    logic                   in_range, allow_hit, ovr_active, rate_hit;
    logic [1:0]             dec_reason;
    logic                   accept, grant_evt, deny_evt;

    logic unused_addr;
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    assign word        = addr[7:2];
    assign mmio_go     = sel & ~ack_q;
    assign cfg_wr      = mmio_go & wr & ~ctrl_lock_q;
    assign rate_win_wr = cfg_wr && (word == WordRateWin);

    always_comb begin
        allow_flat = '0;
        rd_allow   = '0;
        for (int unsigned i = 0; i < ALLOW_WORDS; i++) begin
            allow_flat[i*32 +: 32] = allow_q[i];
            if (word[5:4] == 2'b01 && word[3:0] == 4'(i)) rd_allow = allow_q[i];
        end
    end

    always_comb begin
        case (word)
            WordCtrl:     rd_mux = {30'b0, ctrl_lock_q, ctrl_en_q};
            WordRateLim:  rd_mux = rate_lim_q;
            WordRateWin:  rd_mux = rate_win_q;
            WordPolicy:   rd_mux = policy_q;
            WordOverride: rd_mux = override_q;
            WordNonce:    rd_mux = nonce_q;
            WordDenyCnt:  rd_mux = deny_cnt_q;
            WordStatus:   rd_mux = {30'b0, lock_fuse, ctrl_lock_q};
            default:      rd_mux = rd_allow;
        endcase
    end

    // Decision always uses the register values as they stand before this edge's write.
    assign in_range   = 32'(req_target) < NUM_TARGETS;
    assign allow_hit  = allow_flat[req_target[IDX_W-1:0]];
    assign ovr_active = override_q[0] & ~lock_fuse;
    assign rate_hit   = (rate_win_q != 32'd0) && (commit_cnt_q >= rate_lim_q);

    always_comb begin
        dec_reason = ReasonOk;
        if (!ctrl_en_q) begin
            dec_reason = ReasonDisabled;
        end else if (!in_range || (!allow_hit && !ovr_active)) begin
            dec_reason = ReasonNotAllowed;
        end else if (rate_hit) begin
            dec_reason = ReasonRate;
        end
    end

    assign accept    = (state_q == StIdle) & req_valid;
    assign grant_evt = accept & (dec_reason == ReasonOk);
    assign deny_evt  = accept & (dec_reason != ReasonOk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= mmio_go;
            if (mmio_go) rdata_q <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q   <= 1'b0;
            ctrl_lock_q <= 1'b0;
            rate_lim_q  <= 32'd10;
            rate_win_q  <= 32'd1000;
            policy_q    <= '0;
            override_q  <= '0;
            for (int unsigned i = 0; i < ALLOW_WORDS; i++) allow_q[i] <= '0;
        end else if (cfg_wr) begin
            case (word)
                WordCtrl: begin
                    ctrl_en_q   <= wdata[0];
                    ctrl_lock_q <= ctrl_lock_q | wdata[1];
                end
                WordRateLim:  rate_lim_q <= wdata;
                WordRateWin:  rate_win_q <= wdata;
                WordPolicy:   policy_q   <= wdata;
                WordOverride: if (!lock_fuse) override_q <= wdata;
                default: begin
                    for (int unsigned i = 0; i < ALLOW_WORDS; i++) begin
                        if (word[5:4] == 2'b01 && word[3:0] == 4'(i)) allow_q[i] <= wdata;
                    end
                end
            endcase
        end
    end

    // A grant on the wrap edge is the first commit of the new window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q    <= '0;
            commit_cnt_q <= '0;
        end else if (rate_win_wr) begin
            win_cnt_q    <= '0;
            commit_cnt_q <= '0;
        end else if (rate_win_q != 32'd0) begin
            if (win_cnt_q >= rate_win_q - 32'd1) begin
                win_cnt_q    <= '0;
                commit_cnt_q <= grant_evt ? 32'd1 : 32'd0;
            end else begin
                win_cnt_q <= win_cnt_q + 32'd1;
                if (grant_evt && commit_cnt_q != 32'hFFFF_FFFF) begin
                    commit_cnt_q <= commit_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q    <= '0;
            deny_cnt_q <= '0;
        end else begin
            if (grant_evt) nonce_q <= nonce_q + 32'd1;
            if (deny_evt && deny_cnt_q != 32'hFFFF_FFFF) deny_cnt_q <= deny_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_grant_q  <= 1'b0;
            resp_reason_q <= ReasonOk;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_q       <= StResp;
                        req_ready_q   <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_grant_q  <= (dec_reason == ReasonOk);
                        resp_reason_q <= dec_reason;
                    end
                end
                StResp: begin
                    state_q       <= StIdle;
                    req_ready_q   <= 1'b1;
                    resp_valid_q  <= 1'b0;
                    resp_grant_q  <= 1'b0;
                    resp_reason_q <= ReasonOk;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_grant  = resp_grant_q;
    assign resp_reason = resp_reason_q;
    assign nonce       = nonce_q;

endmodule

// File: tb/tb_boreal_gate_engine.sv
// Bench for boreal_gate_engine: directed scenarios plus randomized MMIO/request traffic
// checked every cycle against a window-indexed behavioural model.
module tb_boreal_gate_engine;

    localparam int unsigned NT = 64;
    localparam int unsigned TW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0, wr = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic          lock_fuse = 1'b0;
    logic          req_valid = 1'b0;
    logic [TW-1:0] req_target = '0;
    logic [31:0]   rdata, nonce;
    logic          ack, req_ready, resp_valid, resp_grant;
    logic [1:0]    resp_reason;

    int n_checks = 0;
    int n_fail   = 0;

    boreal_gate_engine #(.NUM_TARGETS(NT), .TGT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .lock_fuse(lock_fuse), .req_valid(req_valid),
        .req_target(req_target), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_grant(resp_grant), .resp_reason(resp_reason), .nonce(nonce)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model. The rate window is tracked as an absolute cycle position m_n since
    // the last window restart; a grant leaving position n belongs to window (n+1)/RATE_WIN.
    bit          m_en, m_lock, m_busy, m_ack, m_rv, m_grant, m_rd_read;
    logic [31:0] m_allow [2];
    logic [31:0] m_rlim, m_rwin, m_pol, m_ovr, m_nonce, m_deny, m_rdata;
    logic [31:0] m_n, m_wid, m_cnt;
    logic [1:0]  m_reason;

    task automatic m_reset();
        m_en = 0; m_lock = 0; m_busy = 0; m_ack = 0; m_rv = 0; m_grant = 0; m_rd_read = 0;
        m_allow[0] = '0; m_allow[1] = '0;
        m_rlim = 10; m_rwin = 1000; m_pol = '0; m_ovr = '0; m_nonce = '0; m_deny = '0;
        m_rdata = '0; m_n = '0; m_wid = '0; m_cnt = '0; m_reason = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a[7:2])
            6'h00:   return {30'b0, m_lock, m_en};
            6'h02:   return m_rlim;
            6'h03:   return m_rwin;
            6'h04:   return m_pol;
            6'h05:   return m_ovr;
            6'h06:   return m_nonce;
            6'h07:   return m_deny;
            6'h08:   return {30'b0, lock_fuse, m_lock};
            6'h10:   return m_allow[0];
            6'h11:   return m_allow[1];
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] m_decide(input int unsigned t);
        logic [31:0] commits;
        bit          allowed;
        commits = (m_rwin != 0 && (m_n / m_rwin) == m_wid) ? m_cnt : 32'd0;
        allowed = (t < NT) && (m_allow[t / 32][t % 32] || (m_ovr[0] && !lock_fuse));
        if (!m_en) return 2'd1;
        if (!allowed) return 2'd2;
        if (m_rwin != 0 && commits >= m_rlim) return 2'd3;
        return 2'd0;
    endfunction

    task automatic m_step();
        bit          do_ack, acc;
        logic [1:0]  r;
        logic [31:0] wid;
        do_ack = sel && !m_ack;
        acc    = !m_busy && req_valid;
        r      = m_decide(int'(req_target));
        if (do_ack) m_rdata = m_read(addr[7:0]);
        m_rd_read = do_ack && !wr;
        if (acc && r == 2'd0 && m_rwin != 0) begin
            wid = (m_n + 1) / m_rwin;
            if (wid != m_wid) begin m_wid = wid; m_cnt = 1; end
            else m_cnt = m_cnt + 1;
        end
        if (m_rwin != 0) m_n = m_n + 1;
        if (do_ack && wr && !m_lock) begin
            case (addr[7:2])
                6'h00: begin m_en = wdata[0]; m_lock = m_lock | wdata[1]; end
                6'h02: m_rlim = wdata;
                6'h03: begin m_rwin = wdata; m_n = 0; m_wid = 0; m_cnt = 0; end
                6'h04: m_pol = wdata;
                6'h05: if (!lock_fuse) m_ovr = wdata;
                6'h10: m_allow[0] = wdata;
                6'h11: m_allow[1] = wdata;
                default: ;
            endcase
        end
        if (acc) begin
            if (r == 2'd0) m_nonce = m_nonce + 1;
            else if (m_deny != 32'hFFFF_FFFF) m_deny = m_deny + 1;
        end
        m_rv = acc; m_busy = acc; m_grant = acc && r == 2'd0; m_reason = acc ? r : 2'd0;
        m_ack = do_ack;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("cyc_req_ready", req_ready, !m_busy);
        check("cyc_resp_valid", resp_valid, m_rv);
        check("cyc_ack", ack, m_ack);
        check("cyc_nonce", nonce, m_nonce);
        if (m_rv) begin
            check("cyc_grant", resp_grant, m_grant);
            check("cyc_reason", resp_reason, m_reason);
        end
        if (m_ack && m_rd_read) check("cyc_rdata", rdata, m_rdata);
    end

    task automatic mmio(input bit w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] q);
        @(posedge clk); #1;
        sel = 1'b1; wr = w; addr = {24'h0, a}; wdata = d;
        @(posedge clk); #1;
        check("mmio_ack", ack, 1);
        q = rdata;
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        mmio(1'b1, a, d, q);
    endtask

    task automatic rreg(input logic [7:0] a, output logic [31:0] q);
        mmio(1'b0, a, 32'h0, q);
    endtask

    task automatic request(input int unsigned t, output logic g, output logic [1:0] r);
        @(posedge clk); #1;
        req_valid = 1'b1; req_target = TW'(t);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_resp_pulse", resp_valid, 1);
        g = resp_grant; r = resp_reason;
    endtask

    logic [7:0] addrs [15] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                               8'h20, 8'h24, 8'h40, 8'h44, 8'h48, 8'h80, 8'hFC};

    initial begin
        logic [31:0] q;
        logic        g;
        logic [1:0]  r;
        bit          found;

        #22 rst_n = 1'b1;

        // Reset values and disabled deny
        check("rst_req_ready", req_ready, 1);
        rreg(8'h08, q); check("rst_rate_lim", q, 32'h0A);
        rreg(8'h0C, q); check("rst_rate_win", q, 32'h3E8);
        rreg(8'h18, q); check("rst_nonce", q, 0);
        request(5, g, r);
        check("dis_grant", g, 0); check("dis_reason", r, 1);
        rreg(8'h1C, q); check("dis_deny_cnt", q, 1);

        // Allowlist
        wreg(8'h00, 32'h1);
        wreg(8'h44, 32'h0000_0004);
        request(34, g, r);
        check("allow34_grant", g, 1); check("allow34_reason", r, 0);
        check("allow34_nonce", nonce, 1);
        request(35, g, r); check("allow35_reason", r, 2);
        request(70, g, r); check("range70_reason", r, 2);

        // Rate limiter: 3 per 20-cycle window
        wreg(8'h40, 32'hFFFF_FFFF);
        wreg(8'h44, 32'hFFFF_FFFF);
        wreg(8'h08, 32'd3);
        wreg(8'h0C, 32'd20);
        for (int i = 0; i < 3; i++) begin
            request(1, g, r); check("rate_in_budget", r, 0);
        end
        request(1, g, r); check("rate_limited", r, 3);
        found = 0;
        for (int i = 0; i < 15; i++) begin
            request(1, g, r);
            if (r == 2'd0) begin found = 1; break; end
        end
        check("rate_wrap_grant", found, 1);

        // Override and fuse
        wreg(8'h0C, 32'd0);
        wreg(8'h40, 32'd0);
        wreg(8'h14, 32'd1);
        request(5, g, r); check("ovr_grant", r, 0);
        lock_fuse = 1'b1;
        request(5, g, r); check("fuse_reason", r, 2);
        wreg(8'h14, 32'd0);
        rreg(8'h14, q); check("fuse_ovr_kept", q, 1);
        lock_fuse = 1'b0;

        // Randomized traffic
        wreg(8'h00, 32'h1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (sel) begin
                if (ack) begin sel = 1'b0; wr = 1'b0; end
            end else if ($urandom_range(0, 2) == 0) begin
                sel   = 1'b1;
                wr    = ($urandom_range(0, 1) == 1);
                addr  = {24'h0, addrs[$urandom_range(0, 14)]};
                wdata = $urandom;
                case (addr[7:0])
                    8'h00: wdata = {31'b0, ($urandom_range(0, 9) != 0)};
                    8'h08: wdata = $urandom_range(0, 6);
                    8'h0C: wdata = $urandom_range(0, 25);
                    8'h14: wdata = $urandom_range(0, 1);
                    default: ;
                endcase
            end
            req_valid  = ($urandom_range(0, 1) == 1);
            req_target = TW'($urandom_range(0, 75));
            if ($urandom_range(0, 49) == 0) lock_fuse = ~lock_fuse;
        end
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0; req_valid = 1'b0; lock_fuse = 1'b0;
        repeat (2) @(posedge clk);

        // Lock
        wreg(8'h40, 32'd0);
        wreg(8'h14, 32'd0);
        wreg(8'h0C, 32'd0);
        wreg(8'h00, 32'h3);
        wreg(8'h40, 32'hFFFF_FFFF);
        rreg(8'h40, q); check("lock_allow_kept", q, 0);
        request(3, g, r); check("lock_reason", r, 2);
        wreg(8'h00, 32'h0);
        rreg(8'h00, q); check("lock_ctrl_kept", q, 3);
        rreg(8'h20, q); check("lock_status", q, 1);

        // Reset during the response cycle
        request(3, g, r);
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rreg(8'h00, q); check("post_ctrl", q, 0);
        rreg(8'h08, q); check("post_rate_lim", q, 32'h0A);
        rreg(8'h0C, q); check("post_rate_win", q, 32'h3E8);
        rreg(8'h40, q); check("post_allow0", q, 0);
        rreg(8'h1C, q); check("post_deny", q, 0);
        rreg(8'h18, q); check("post_nonce_reg", q, 0);
        check("post_nonce_port", nonce, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
